// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-RAM arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and RAM-side signals of the data-RAM arbiter
interface dmem_arbiter_if #(parameter int DWIDTH = 32);

  logic [1:0]        req_i;
  logic [1:0]        we_i;
  logic [DWIDTH-1:0] addr0_i;
  logic [DWIDTH-1:0] addr1_i;
  logic [DWIDTH-1:0] wdata0_i;
  logic [DWIDTH-1:0] wdata1_i;
  logic [1:0]        ack_o;
  logic              err_o;
  logic [DWIDTH-1:0] rdata_o;
  logic              cpu_stall;
  logic              ram_r;
  logic              ram_w;
  logic [DWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [DWIDTH-1:0] ram_rdata;

  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ram_rdata,
    output ack_o, err_o, rdata_o, cpu_stall, ram_r, ram_w, ram_addr, ram_wdata
  );

  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ram_rdata,
    input  ack_o, err_o, rdata_o, cpu_stall, ram_r, ram_w, ram_addr, ram_wdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // On a tie the port that did not win last time goes next.
  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? ~last : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of the single-port data RAM between CPU and debug ports
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic              port_q;
  logic              last_q;
  logic              we_q;
  logic              err_q;
  logic [DWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;

  logic [1:0]        arb_req;
  logic              gnt_valid;
  logic              gnt_id;
  logic              load;
  logic              in_range;
  logic              in_access;
  logic              in_done;

  // While acking, the acked port's request is stale and must not win again.
  always_comb begin
    arb_req = bus.req_i;
    if (state_q == ARB_DONE) arb_req[port_q] = 1'b0;
  end

  rr_arb2 u_rr_arb2 (
    .req       (arb_req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign in_range  = addr_q < DWIDTH'(DEPTH);
  assign in_access = (state_q == ARB_ACCESS);
  assign in_done   = (state_q == ARB_DONE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          load    = 1'b1;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: state_d = ARB_DONE;
      ARB_DONE: begin
        if (gnt_valid) begin
          load    = 1'b1;
          state_d = ARB_ACCESS;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        port_q  <= gnt_id;
        last_q  <= gnt_id;
        we_q    <= bus.we_i[gnt_id];
        addr_q  <= gnt_id ? bus.addr1_i : bus.addr0_i;
        wdata_q <= gnt_id ? bus.wdata1_i : bus.wdata0_i;
      end
      if (in_access) err_q <= ~in_range;
    end
  end

  assign bus.ram_r     = in_access & in_range & ~we_q;
  assign bus.ram_w     = in_access & in_range & we_q;
  assign bus.ram_addr  = in_access ? addr_q : '0;
  assign bus.ram_wdata = in_access ? wdata_q : '0;

  assign bus.ack_o     = {in_done & port_q, in_done & ~port_q};
  assign bus.err_o     = in_done & err_q;
  assign bus.rdata_o   = (in_done && !we_q && !err_q) ? bus.ram_rdata : '0;
  // Gated by reset so every output reads zero while reset is held.
  assign bus.cpu_stall = reset & bus.req_i[PORT_CPU] & ~bus.ack_o[PORT_CPU];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic clock;
  logic reset;

  dmem_arbiter_if #(.DWIDTH(32)) bus ();

  dmem_arbiter #(.DWIDTH(32), .DEPTH(1024)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic        req0, req1, we0, we1;
  logic [31:0] a0, a1, d0, d1;
  logic [31:0] ram_rdata_q;
  logic [31:0] mem [int];

  assign bus.req_i     = {req1, req0};
  assign bus.we_i      = {we1, we0};
  assign bus.addr0_i   = a0;
  assign bus.addr1_i   = a1;
  assign bus.wdata0_i  = d0;
  assign bus.wdata1_i  = d1;
  assign bus.ram_rdata = ram_rdata_q;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   wr_cnt = 0;
  int   stall_cnt = 0;
  int   ack_log[$];
  int   strobe_log[$];
  exp_t q0[$];
  exp_t q1[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int k;
    k = int'(a);
    return mem.exists(k) ? mem[k] : (32'hA000_0000 + a);
  endfunction

  // RAM model: registered read, writes only inside the array.
  always @(posedge clock) begin
    if (bus.ram_r) ram_rdata_q <= mem_rd(bus.ram_addr);
    if (bus.ram_w && bus.ram_addr < 32'd1024) mem[int'(bus.ram_addr)] = bus.ram_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected response of whichever port is acked.
  always @(negedge clock) begin
    exp_t e;
    int   p;
    cyc++;
    chk("ram_r_w_exclusive", {63'd0, bus.ram_r & bus.ram_w}, 64'd0);
    if (bus.ram_r || bus.ram_w) begin
      strobe_cnt++;
      strobe_log.push_back(cyc);
      if (bus.ram_w) wr_cnt++;
    end
    if (bus.cpu_stall) stall_cnt++;
    if (bus.ack_o != 2'b00) begin
      chk("ack_onehot", {63'd0, $onehot(bus.ack_o)}, 64'd1);
      chk("ack_in_done", {63'd0, dut.state_q == ARB_DONE}, 64'd1);
      p = bus.ack_o[1] ? 1 : 0;
      ack_log.push_back(p);
      if (p == 0 && q0.size() > 0) begin
        e = q0.pop_front();
        chk("p0_response", {31'd0, bus.err_o, bus.rdata_o}, {31'd0, e.err, e.rd});
      end else if (p == 1 && q1.size() > 0) begin
        e = q1.pop_front();
        chk("p1_response", {31'd0, bus.err_o, bus.rdata_o}, {31'd0, e.err, e.rd});
      end else begin
        chk("unexpected_ack", {62'd0, bus.ack_o}, 64'd0);
      end
    end
  end

  // Starts and ends at posedge+1; req stays high until the cycle after ack.
  task automatic access(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input bit err, input logic [31:0] exp_rd, output int lat);
    exp_t e;
    e.err = err;
    e.rd  = exp_rd;
    if (p == 0) begin
      q0.push_back(e);
      we0 = we; a0 = a; d0 = d; req0 = 1'b1;
    end else begin
      q1.push_back(e);
      we1 = we; a1 = a; d1 = d; req1 = 1'b1;
    end
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.ack_o[p] && lat < 40);
    if (!bus.ack_o[p]) chk("ack_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  initial begin
    int lat, s0, w0, st0, n;
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    repeat (2) @(posedge clock);
    #1;

    // 1: both request during reset; port 0 wins the first tie
    ack_log.delete();
    fork
      access(0, 0, 32'd3, 32'd0, 0, 32'hA000_0003, lat);
      access(1, 0, 32'd4, 32'd0, 0, 32'hA000_0004, lat);
      begin
        repeat (2) begin
          @(negedge clock);
          chk("reset_ctl", {58'd0, bus.ack_o, bus.err_o, bus.cpu_stall, bus.ram_r, bus.ram_w}, 64'd0);
          chk("reset_bus", {32'd0, bus.rdata_o | bus.ram_addr | bus.ram_wdata}, 64'd0);
        end
        @(posedge clock);
        #1 reset = 1'b1;
      end
    join
    chk("t1_ack_count", 64'(ack_log.size()), 64'd2);
    if (ack_log.size() == 2) begin
      chk("t1_first_ack", 64'(ack_log[0]), 64'd0);
      chk("t1_second_ack", 64'(ack_log[1]), 64'd1);
    end

    // 2: store then load at word 5; latency, single write strobe, stall window
    s0 = stall_cnt; w0 = wr_cnt;
    access(0, 1, 32'd5, 32'hDEAD_BEEF, 0, 32'd0, lat);
    chk("t2_store_latency", 64'(lat), 64'd3);
    chk("t2_write_strobes", 64'(wr_cnt - w0), 64'd1);
    chk("t2_stall_cycles", 64'(stall_cnt - s0), 64'd2);
    access(0, 0, 32'd5, 32'd0, 0, 32'hDEAD_BEEF, lat);
    chk("t2_load_latency", 64'(lat), 64'd3);

    // 3: both ports busy for 8 accesses; strict alternation, strobe every 2 cycles
    ack_log.delete();
    strobe_log.delete();
    fork
      for (int i = 0; i < 4; i++) access(0, 1, 32'(10 + i), 32'h5000 + 32'(i), 0, 32'd0, lat);
      begin
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) access(1, 0, 32'(20 + i), 32'd0, 0, 32'hA000_0014 + 32'(i), lat);
      end
    join
    chk("t3_ack_count", 64'(ack_log.size()), 64'd8);
    chk("t3_strobe_count", 64'(strobe_log.size()), 64'd8);
    n = (ack_log.size() < 8) ? ack_log.size() : 8;
    for (int i = 0; i < n; i++) chk("t3_ack_order", 64'(ack_log[i]), 64'(i % 2));
    n = (strobe_log.size() < 8) ? strobe_log.size() : 8;
    for (int i = 1; i < n; i++) chk("t3_strobe_spacing", 64'(strobe_log[i] - strobe_log[i-1]), 64'd2);

    // 4: out-of-range boundaries, then an in-range access clears err
    st0 = strobe_cnt;
    access(1, 0, 32'd1024, 32'd0, 1, 32'd0, lat);
    access(0, 0, 32'h0001_0005, 32'd0, 1, 32'd0, lat);
    chk("t4_no_strobe", 64'(strobe_cnt - st0), 64'd0);
    access(1, 0, 32'd6, 32'd0, 0, 32'hA000_0006, lat);
    access(0, 0, 32'd1023, 32'd0, 0, 32'hA000_03FF, lat);

    // 5: reset during the ACCESS of a port 1 write to word 7
    we1 = 1; a1 = 32'd7; d1 = 32'h1234_5678; req1 = 1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.ram_w && n < 10);
    chk("t5_reached_access", {63'd0, bus.ram_w}, 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_ram_w_drops", {63'd0, bus.ram_w}, 64'd0);
    @(posedge clock);
    #1;
    req1 = 0; we1 = 0;
    @(negedge clock);
    chk("t5_idle_in_reset", {62'd0, dut.state_q}, {62'd0, ARB_IDLE});
    @(posedge clock);
    #1 reset = 1'b1;
    chk("t5_word7_kept", {32'd0, mem_rd(32'd7)}, {32'd0, 32'hA000_0007});
    access(0, 0, 32'd7, 32'd0, 0, 32'hA000_0007, lat);
    chk("t5_restart_latency", 64'(lat), 64'd3);

    // 6: port 0 withdraws req mid-access; the ack still pulses
    begin
      exp_t e;
      e.err = 1'b0;
      e.rd  = 32'hA000_0008;
      q0.push_back(e);
    end
    we0 = 0; a0 = 32'd8; req0 = 1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.ram_r && n < 10);
    chk("t6_reached_access", {63'd0, bus.ram_r}, 64'd1);
    req0 = 0;
    @(negedge clock);
    chk("t6_ack_pulse", {62'd0, bus.ack_o}, 64'd1);
    @(negedge clock);
    chk("t6_back_to_idle", {62'd0, dut.state_q}, {62'd0, ARB_IDLE});
    chk("t6_quiet", {61'd0, bus.ack_o, bus.ram_r | bus.ram_w}, 64'd0);

    repeat (2) @(negedge clock);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
